serial_alu_seq: RTL and testbench

Bit-serial ALU sequencer. Accepts one 32-bit operation per request and executes it LSB-first through a single instance of the team's 1-bit ALU slice, one bit per clock. It holds the inter-bit carry, handles the set-less-than fix-up, and presents word-level result and flags with a done pulse. It is the area-reduced ALU option for the MIPS-subset core's multi-cycle/debug path.

---
 rtl/serial_alu_seq.sv | 201 ++++++++++++++++++++
 tb/tb_serial_alu_seq.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_alu_seq.sv
// serial_alu_seq: bit-serial 32-bit ALU sequencer.
// One operation is latched on start, walked LSB-first through a single
// 1-bit ALU slice (one bit per clock), then committed to the word-level
// result/flag registers on the FIX edge, followed by a one-cycle done pulse.
//
// Handshake: start is sampled only when busy=0 (IDLE or DONE); a start seen
// there is accepted on that edge, busy rises the next cycle, and done pulses
// for exactly one cycle WIDTH+2 cycles after acceptance. start while busy=1
// is dropped. Results/flags hold from one FIX edge to the next.

// 1-bit ALU slice. ctrl[3] inverts B (subtract/compare); the carry-in of
// bit 0 supplies the +1 of the two's complement. set is the less-than
// indication meaningful at the MSB: signed (sum ^ overflow) for SLT,
// unsigned (borrow = ~carry) for SLTU.
module alu_1bit (
    input  logic       a_i,
    input  logic       b_i,
    input  logic       carry_i,
    input  logic       less_i,
    input  logic [3:0] ctrl_i,
    output logic       result_o,
    output logic       carry_o,
    output logic       set_o,
    output logic       overflow_o
);
    logic bb;
    logic sum;

    // Full adder with optional B inversion plus per-op result select
    always_comb begin
        bb         = b_i ^ ctrl_i[3];
        sum        = a_i ^ bb ^ carry_i;
        carry_o    = (a_i & bb) | (a_i & carry_i) | (bb & carry_i);
        overflow_o = carry_i ^ carry_o;
        set_o      = (ctrl_i == 4'd12) ? ~carry_o : (sum ^ overflow_o);
        case (ctrl_i)
            4'd0:          result_o = a_i & b_i;
            4'd1:          result_o = a_i | b_i;
            4'd2, 4'd10:   result_o = sum;
            4'd3:          result_o = a_i ^ b_i;
            4'd11, 4'd12:  result_o = less_i;
            default:       result_o = 1'b0;
        endcase
    end
endmodule

module serial_alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow,
    output logic             zero,
    output logic [1:0]       dbg_state
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_XOR  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd10;
    localparam logic [3:0] OP_SLT  = 4'd11;
    localparam logic [3:0] OP_SLTU = 4'd12;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, b_q, shadow_q, result_q;
    logic [3:0]         ctrl_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               carry_q, set_q, ov_q, co_q;
    logic               carryout_q, overflow_q, zero_q;

    logic               accept, last_bit;
    logic               slice_result, slice_carry, slice_set, slice_ov;
    logic               op_valid, op_slt, op_arith, op_ovf;
    logic [WIDTH-1:0]   fix_result;

    assign accept   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    alu_1bit u_slice (
        .a_i        (a_q[cnt_q]),
        .b_i        (b_q[cnt_q]),
        .carry_i    (carry_q),
        .less_i     (1'b0),
        .ctrl_i     (ctrl_q),
        .result_o   (slice_result),
        .carry_o    (slice_carry),
        .set_o      (slice_set),
        .overflow_o (slice_ov)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state and status outputs
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: if (accept) state_d = S_RUN;
            S_RUN: begin
                busy = 1'b1;
                if (last_bit) state_d = S_FIX;
            end
            S_FIX: begin
                busy    = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = accept ? S_RUN : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Op classification and final word assembly used on the FIX edge
    always_comb begin
        op_valid = (ctrl_q == OP_AND) || (ctrl_q == OP_OR) || (ctrl_q == OP_ADD) ||
                   (ctrl_q == OP_XOR) || (ctrl_q == OP_SUB) || (ctrl_q == OP_SLT) ||
                   (ctrl_q == OP_SLTU);
        op_slt   = (ctrl_q == OP_SLT) || (ctrl_q == OP_SLTU);
        op_arith = (ctrl_q == OP_ADD) || (ctrl_q == OP_SUB) || op_slt;
        op_ovf   = (ctrl_q == OP_ADD) || (ctrl_q == OP_SUB);
        fix_result = '0;
        if (op_valid) begin
            fix_result = shadow_q;
            if (op_slt) fix_result[0] = set_q;
        end
    end

    // Operand latch, serial bit walk, and word-level commit
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q        <= '0;
            b_q        <= '0;
            ctrl_q     <= '0;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            shadow_q   <= '0;
            set_q      <= 1'b0;
            ov_q       <= 1'b0;
            co_q       <= 1'b0;
            result_q   <= '0;
            carryout_q <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            if (accept) begin
                a_q     <= a;
                b_q     <= b;
                ctrl_q  <= ctrl;
                cnt_q   <= '0;
                carry_q <= ctrl[3];
            end
            if (state_q == S_RUN) begin
                shadow_q[cnt_q] <= slice_result;
                carry_q         <= slice_carry;
                if (last_bit) begin
                    set_q <= slice_set;
                    ov_q  <= slice_ov;
                    co_q  <= slice_carry;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
            if (state_q == S_FIX) begin
                result_q   <= fix_result;
                carryout_q <= op_arith & co_q;
                overflow_q <= op_ovf & ov_q;
                zero_q     <= (fix_result == '0);
            end
        end
    end

    assign result    = result_q;
    assign carryout  = carryout_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_serial_alu_seq.sv
// Directed bench for serial_alu_seq: reset values, arithmetic/compare and
// logic ops with hand-computed results, ignored start, mid-op reset, and
// back-to-back operation.
module tb_serial_alu_seq;
    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [3:0]    ctrl;
    logic [W-1:0]  a, b;
    logic          busy, done, carryout, overflow, zero;
    logic [W-1:0]  result;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]   c;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic         co;
        logic         ov;
        logic         z;
    } vec_t;

    serial_alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ctrl      (ctrl),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carryout  (carryout),
        .overflow  (overflow),
        .zero      (zero),
        .dbg_state (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    // Driver: present an op, let the next rising edge accept it, then drop
    // start and scramble the operand pins.
    task automatic start_op(input logic [3:0] c, input logic [W-1:0] av, input logic [W-1:0] bv);
        ctrl  = c;
        a     = av;
        b     = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        ctrl  = 4'($urandom_range(0, 15));
    endtask

    // Driver: wait for done. lat = number of rising edges after the accept
    // edge up to the edge at which done is sampled high (-1 on timeout).
    // busy_ok = busy was high on every sample before done and low with done.
    task automatic wait_done(output int lat, output bit busy_ok);
        lat     = -1;
        busy_ok = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = n + 1;
                if (busy !== 1'b0) busy_ok = 1'b0;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; ctrl = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, carryout, overflow, zero} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got busy=%b done=%b co=%b ov=%b z=%b expected all 0",
                     busy, done, carryout, overflow, zero);
        end
        checks++;
        if (result !== '0) begin
            errors++;
            $display("FAIL reset_result got %h expected 0", result);
        end
        checks++;
        if (dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_state got %0d expected 0", dbg_state);
        end
    endtask

    task automatic test_arith();
        vec_t v[7];
        int   lat;
        bit   bok;
        v[0] = '{4'd2,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0};
        v[1] = '{4'd10, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b1};
        v[2] = '{4'd10, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        v[3] = '{4'd11, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b1, 1'b0, 1'b0};
        v[4] = '{4'd12, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1};
        v[5] = '{4'd11, 32'h80000000, 32'h00000001, 32'h00000001, 1'b1, 1'b0, 1'b0};
        v[6] = '{4'd2,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            start_op(v[i].c, v[i].a, v[i].b);
            wait_done(lat, bok);
            checks++;
            if (lat != LAT) begin
                errors++;
                $display("FAIL arith%0d_latency got %0d expected %0d", i, lat, LAT);
            end
            checks++;
            if (!bok) begin
                errors++;
                $display("FAIL arith%0d_busy got bad busy profile expected high until done", i);
            end
            checks++;
            if (result !== v[i].r) begin
                errors++;
                $display("FAIL arith%0d_result got %h expected %h", i, result, v[i].r);
            end
            checks++;
            if ({carryout, overflow, zero} !== {v[i].co, v[i].ov, v[i].z}) begin
                errors++;
                $display("FAIL arith%0d_flags got co/ov/z=%b%b%b expected %b%b%b",
                         i, carryout, overflow, zero, v[i].co, v[i].ov, v[i].z);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL arith%0d_pulse got done=%b expected 0", i, done);
            end
        end
    endtask

    task automatic test_logic();
        vec_t v[4];
        int   lat;
        bit   bok;
        v[0] = '{4'd3, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0};
        v[1] = '{4'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0};
        v[2] = '{4'd1, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0};
        v[3] = '{4'd5, 32'hF0F0F0F0, 32'hFF00FF00, 32'h00000000, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            start_op(v[i].c, v[i].a, v[i].b);
            wait_done(lat, bok);
            checks++;
            if (lat != LAT) begin
                errors++;
                $display("FAIL logic%0d_latency got %0d expected %0d", i, lat, LAT);
            end
            checks++;
            if (result !== v[i].r) begin
                errors++;
                $display("FAIL logic%0d_result got %h expected %h", i, result, v[i].r);
            end
            checks++;
            if ({carryout, overflow, zero} !== {v[i].co, v[i].ov, v[i].z}) begin
                errors++;
                $display("FAIL logic%0d_flags got co/ov/z=%b%b%b expected %b%b%b",
                         i, carryout, overflow, zero, v[i].co, v[i].ov, v[i].z);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        bit bok;
        bit extra;
        start_op(4'd2, 32'h12345678, 32'h11111111);
        repeat (5) @(negedge clk);
        ctrl = 4'd0; a = 32'hFFFFFFFF; b = 32'h00000000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bok);
        checks++;
        if (lat + 6 != LAT) begin
            errors++;
            $display("FAIL ignore_latency got %0d expected %0d", lat + 6, LAT);
        end
        checks++;
        if (result !== 32'h23456789) begin
            errors++;
            $display("FAIL ignore_result got %h expected 23456789", result);
        end
        extra = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) extra = 1'b1;
        end
        checks++;
        if (extra) begin
            errors++;
            $display("FAIL ignore_second_op got extra busy/done expected none");
        end
    endtask

    task automatic test_rst_mid();
        int lat;
        bit bok;
        bit extra;
        start_op(4'd10, 32'h80000000, 32'h00000001);
        wait_done(lat, bok);
        @(negedge clk);
        start_op(4'd2, 32'h7FFFFFFF, 32'h7FFFFFFF);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, done, carryout, overflow, zero} !== 5'b0) begin
            errors++;
            $display("FAIL rstmid_flags got busy=%b done=%b co=%b ov=%b z=%b expected all 0",
                     busy, done, carryout, overflow, zero);
        end
        checks++;
        if (result !== '0) begin
            errors++;
            $display("FAIL rstmid_result got %h expected 0", result);
        end
        extra = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done !== 1'b0) extra = 1'b1;
        end
        checks++;
        if (extra) begin
            errors++;
            $display("FAIL rstmid_no_done got done after reset expected none");
        end
        start_op(4'd2, 32'd2, 32'd3);
        wait_done(lat, bok);
        checks++;
        if (lat != LAT) begin
            errors++;
            $display("FAIL rstmid_add_latency got %0d expected %0d", lat, LAT);
        end
        checks++;
        if (result !== 32'd5 || zero !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_add_result got %h z=%b expected 00000005 z=0", result, zero);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat;
        bit bok;
        start_op(4'd2, 32'h7FFFFFFF, 32'h00000001);
        wait_done(lat, bok);
        checks++;
        if (result !== 32'h80000000 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first got %h ov=%b expected 80000000 ov=1", result, overflow);
        end
        // Still in the DONE cycle: start here must be accepted.
        start_op(4'd3, 32'hF0F0F0F0, 32'hFF00FF00);
        wait_done(lat, bok);
        checks++;
        if (lat != LAT) begin
            errors++;
            $display("FAIL b2b_latency got %0d expected %0d", lat, LAT);
        end
        checks++;
        if (result !== 32'h0FF00FF0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second got %h ov=%b expected 0ff00ff0 ov=0", result, overflow);
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ctrl = '0; a = '0; b = '0;
        test_reset();
        test_arith();
        test_logic();
        test_ignore_start();
        test_rst_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
